// File: rtl/traffic_light_monitor.sv
// traffic_light_monitor: passive phase-order / phase-duration checker for a two-road light controller.
// Latency: 1 cycle from a tick sample to every registered output. No backpressure; observes only.
// Optional macro TRAFFIC_LIGHT_MONITOR_PHASE_COUNT_EN enables the completed-phase counter.
module traffic_light_monitor #(
  parameter int GREEN_DELAY  = 30,
  parameter int YELLOW_DELAY = 5,
  parameter int CNT_W        = 8
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        tick,
  input  logic        r1,
  input  logic        y1,
  input  logic        g1,
  input  logic        r2,
  input  logic        y2,
  input  logic        g2,
  input  logic        clear_errors,
  output logic [1:0]  phase,
  output logic        phase_valid,
  output logic        illegal_pattern,
  output logic        seq_error,
  output logic        timing_error,
  output logic        fault,
  output logic [15:0] phase_count
);

  typedef enum logic [1:0] {IDLE = 2'd0, ALIGN = 2'd1, TRACK = 2'd2} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       phase_q, phase_d;
  logic             valid_q, valid_d;
  logic             ill_q, ill_d;
  logic             seq_q, seq_d;
  logic             tim_q, tim_d;
  logic             fault_q, fault_d;

  logic [5:0]       lights;
  logic             legal;
  logic [1:0]       dec;
  logic             same;
  logic             succ;
  logic [CNT_W-1:0] exp_dur;
  logic [CNT_W-1:0] cnt_inc;
  logic             set_ill, set_seq, set_tim;

  assign lights = {r1, y1, g1, r2, y2, g2};

  // Decode the light pattern and derive the comparisons against the current phase.
  always_comb begin
    legal = 1'b1;
    dec   = 2'd0;
    case (lights)
      6'b100001: dec = 2'd0;  // RG
      6'b100010: dec = 2'd1;  // RY
      6'b001100: dec = 2'd2;  // GR
      6'b010100: dec = 2'd3;  // YR
      default:   legal = 1'b0;
    endcase
    same    = (dec == phase_q);
    succ    = (dec == phase_q + 2'd1);
    exp_dur = phase_q[0] ? CNT_W'(YELLOW_DELAY) : CNT_W'(GREEN_DELAY);
    cnt_inc = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + 1'b1;
  end

  // Next-state: FSM, duration counter, phase and the per-sample error events.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    phase_d = phase_q;
    valid_d = valid_q;
    set_ill = 1'b0;
    set_seq = 1'b0;
    set_tim = 1'b0;
    if (tick) begin
      if (!legal) begin
        set_ill = 1'b1;
        state_d = IDLE;
        cnt_d   = '0;
        valid_d = 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            state_d = ALIGN;
            phase_d = dec;
            valid_d = 1'b1;
            cnt_d   = CNT_W'(1);
          end
          ALIGN: begin
            // Partial phase: counted but never judged on length.
            if (same) begin
              cnt_d = cnt_inc;
            end else begin
              if (succ) state_d = TRACK;
              else      set_seq = 1'b1;
              phase_d = dec;
              cnt_d   = CNT_W'(1);
            end
          end
          TRACK: begin
            if (same) begin
              // Flag on the sample that makes the phase one tick too long.
              if (cnt_q == exp_dur) begin
                set_tim = 1'b1;
                state_d = ALIGN;
              end
              cnt_d = cnt_inc;
            end else begin
              if (succ) begin
                if (cnt_q != exp_dur) set_tim = 1'b1;
              end else begin
                set_seq = 1'b1;
                state_d = ALIGN;
              end
              phase_d = dec;
              cnt_d   = CNT_W'(1);
            end
          end
          default: begin
            state_d = IDLE;
            cnt_d   = '0;
            valid_d = 1'b0;
          end
        endcase
      end
    end
  end

  // Sticky flags: a detection in the same cycle overrides clear_errors.
  always_comb begin
    ill_d   = set_ill | (ill_q & ~clear_errors);
    seq_d   = set_seq | (seq_q & ~clear_errors);
    tim_d   = set_tim | (tim_q & ~clear_errors);
    fault_d = ill_d | seq_d | tim_d;
  end

  // State and output registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      phase_q <= 2'd0;
      valid_q <= 1'b0;
      ill_q   <= 1'b0;
      seq_q   <= 1'b0;
      tim_q   <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
      valid_q <= valid_d;
      ill_q   <= ill_d;
      seq_q   <= seq_d;
      tim_q   <= tim_d;
      fault_q <= fault_d;
    end
  end

  assign phase           = phase_q;
  assign phase_valid     = valid_q;
  assign illegal_pattern = ill_q;
  assign seq_error       = seq_q;
  assign timing_error    = tim_q;
  assign fault           = fault_q;

`ifdef TRAFFIC_LIGHT_MONITOR_PHASE_COUNT_EN
  logic [15:0] phase_count_q, phase_count_d;
  logic        adv_ok;

  // A checked phase completes on an in-order, correct-length TRACK transition.
  always_comb begin
    adv_ok        = tick & legal & (state_q == TRACK) & succ & (cnt_q == exp_dur);
    phase_count_d = phase_count_q + {15'd0, adv_ok};
  end

  // Completed-phase counter, cleared only by reset.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) phase_count_q <= 16'd0;
    else          phase_count_q <= phase_count_d;
  end

  assign phase_count = phase_count_q;
`else
  assign phase_count = 16'd0;
`endif

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Directed bench for traffic_light_monitor with immediate-assertion checks.
module tb_traffic_light_monitor;

  localparam logic [5:0] P_RG  = 6'b100001;
  localparam logic [5:0] P_RY  = 6'b100010;
  localparam logic [5:0] P_GR  = 6'b001100;
  localparam logic [5:0] P_YR  = 6'b010100;
  localparam logic [5:0] P_BAD = 6'b101000;  // r1 and g1 together

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        tick = 1'b0;
  logic        r1 = 1'b0, y1 = 1'b0, g1 = 1'b0, r2 = 1'b0, y2 = 1'b0, g2 = 1'b0;
  logic        clear_errors = 1'b0;
  logic [1:0]  phase;
  logic        phase_valid, illegal_pattern, seq_error, timing_error, fault;
  logic [15:0] phase_count;

  int tests = 0;
  int fails = 0;
  int exp_cnt = 0;
  logic [5:0] rnd;

  always #5 clock = ~clock;

  traffic_light_monitor dut (
    .clock(clock), .reset_n(reset_n), .tick(tick),
    .r1(r1), .y1(y1), .g1(g1), .r2(r2), .y2(y2), .g2(g2),
    .clear_errors(clear_errors),
    .phase(phase), .phase_valid(phase_valid), .illegal_pattern(illegal_pattern),
    .seq_error(seq_error), .timing_error(timing_error), .fault(fault),
    .phase_count(phase_count)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
    tests++;
    assert (obs === exp_v) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Checks phase, phase_valid and the three flags; expected fault is their OR.
  task automatic chk_out(input string tag, input logic [1:0] ph, input logic v,
                         input logic il, input logic sq, input logic tm);
    chk(tag, {9'd0, phase, phase_valid, illegal_pattern, seq_error, timing_error, fault},
             {9'd0, ph, v, il, sq, tm, il | sq | tm});
  endtask

  task automatic chk_count(input string tag);
`ifdef TRAFFIC_LIGHT_MONITOR_PHASE_COUNT_EN
    chk(tag, phase_count, 16'(exp_cnt));
`else
    chk(tag, phase_count, 16'd0);
`endif
  endtask

  // n ticked samples of one pattern; outputs are looked at 1ns after each edge.
  task automatic apply(input logic [5:0] pat, input int n, input logic clr);
    for (int i = 0; i < n; i++) begin
      {r1, y1, g1, r2, y2, g2} = pat;
      tick = 1'b1;
      clear_errors = clr;
      @(posedge clock);
      #1;
    end
    tick = 1'b0;
    clear_errors = 1'b0;
  endtask

  task automatic idle(input int n, input logic clr);
    tick = 1'b0;
    clear_errors = clr;
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
    clear_errors = 1'b0;
  endtask

  initial begin
    // 1. Reset held with random lights, then release.
    for (int i = 0; i < 3; i++) begin
      rnd = 6'($urandom_range(0, 63));
      {r1, y1, g1, r2, y2, g2} = rnd;
      tick = 1'b1;
      @(posedge clock);
      #1;
    end
    chk_out("reset_held", 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("reset_held_cnt", phase_count, 16'd0);
    tick = 1'b0;
    reset_n = 1'b1;
    @(posedge clock);
    #1;
    chk_out("reset_release", 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    // 2. Normal cycle: first GR partial, then four checked transitions.
    apply(P_GR, 1, 1'b0);
    chk_out("first_gr", 2'd2, 1'b1, 1'b0, 1'b0, 1'b0);
    apply(P_GR, 9, 1'b0);
    apply(P_YR, 1, 1'b0);
    chk_out("enter_yr", 2'd3, 1'b1, 1'b0, 1'b0, 1'b0);
    apply(P_YR, 4, 1'b0);
    apply(P_RG, 1, 1'b0);
    exp_cnt = 1;
    chk_out("enter_rg", 2'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    apply(P_RG, 29, 1'b0);
    apply(P_RY, 1, 1'b0);
    exp_cnt = 2;
    chk_out("enter_ry", 2'd1, 1'b1, 1'b0, 1'b0, 1'b0);
    apply(P_RY, 4, 1'b0);
    apply(P_GR, 1, 1'b0);
    exp_cnt = 3;
    chk_out("enter_gr", 2'd2, 1'b1, 1'b0, 1'b0, 1'b0);
    chk_count("count_after_gr");
    apply(P_GR, 29, 1'b0);

    // 3. Stuck RG: the 31st sample flags timing.
    apply(P_YR, 5, 1'b0);
    exp_cnt = 4;
    apply(P_RG, 30, 1'b0);
    exp_cnt = 5;
    chk_out("rg_30_ok", 2'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    apply(P_RG, 1, 1'b0);
    chk_out("rg_31_long", 2'd0, 1'b1, 1'b0, 1'b0, 1'b1);
    apply(P_RG, 1, 1'b1);
    chk_out("clear_in_align", 2'd0, 1'b1, 1'b0, 1'b0, 1'b0);

    // 4. Short RY (4 samples) then GR: too short, no sequence error.
    apply(P_RY, 4, 1'b0);
    chk_out("ry_from_align", 2'd1, 1'b1, 1'b0, 1'b0, 1'b0);
    apply(P_GR, 1, 1'b0);
    chk_out("ry_short", 2'd2, 1'b1, 1'b0, 1'b0, 1'b1);
    chk_count("count_no_short");
    idle(1, 1'b1);
    chk_out("clear_no_tick", 2'd2, 1'b1, 1'b0, 1'b0, 1'b0);

    // 5. GR then RG skips YR; following partial RG is unchecked, next RY checked.
    apply(P_GR, 4, 1'b0);
    apply(P_RG, 1, 1'b0);
    chk_out("skip_yr", 2'd0, 1'b1, 1'b0, 1'b1, 1'b0);
    idle(1, 1'b1);
    apply(P_RG, 2, 1'b0);
    apply(P_RY, 1, 1'b0);
    chk_out("partial_rg_ok", 2'd1, 1'b1, 1'b0, 1'b0, 1'b0);
    apply(P_RY, 4, 1'b0);
    apply(P_GR, 1, 1'b0);
    exp_cnt = 6;
    chk_out("ry_checked_ok", 2'd2, 1'b1, 1'b0, 1'b0, 1'b0);
    chk_count("count_after_align");
    // Unticked cycles must not lengthen the phase.
    idle(40, 1'b0);
    apply(P_GR, 29, 1'b0);
    apply(P_YR, 1, 1'b0);
    exp_cnt = 7;
    chk_out("tick_gating", 2'd3, 1'b1, 1'b0, 1'b0, 1'b0);
    chk_count("count_tick_gating");

    // 6. Illegal pattern, clear versus set, then clear with a legal sample.
    apply(P_BAD, 1, 1'b0);
    chk_out("illegal", 2'd3, 1'b0, 1'b1, 1'b0, 1'b0);
    apply(P_BAD, 1, 1'b1);
    chk_out("set_beats_clear", 2'd3, 1'b0, 1'b1, 1'b0, 1'b0);
    apply(P_RG, 1, 1'b1);
    chk_out("clear_legal", 2'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk_count("count_kept");

    // Asynchronous reset mid-phase.
    apply(P_RG, 3, 1'b0);
    reset_n = 1'b0;
    #1;
    chk_out("async_reset", 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("async_reset_cnt", phase_count, 16'd0);
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    idle(1, 1'b0);
    chk_out("after_reset", 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
